wb_stage_buf: RTL

- Parametrised write-back stage for the CPU pipeline; successor to the fixed 10-bit memory/ALU write-back stage.
- Selects a result from one of four sources (ALU, memory, link, immediate) and buffers it in a 2-entry skid queue.
- Drives the register-file write port with a ready/valid handshake, so the register file can stall write-back.
- Also provides a forwarding tap, the last-committed result, a commit counter and a halt latch.

---
 rtl/wb_stage_buf.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/wb_stage_buf.sv
// Write-back stage: selects one of four result sources, holds results in a
// 2-entry in-order skid queue and drains them into the register file with a
// ready/valid handshake. Also exports a forwarding tap on the youngest entry,
// the last retired result, a wrapping commit counter and a sticky halt flag.
module wb_stage_buf #(
    parameter int unsigned WIDTH   = 10,
    parameter int unsigned RA_W    = 3,
    parameter int unsigned COUNT_W = 16,
    parameter bit          R0_ZERO = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_sel,
    input  logic [WIDTH-1:0]   in_alu,
    input  logic [WIDTH-1:0]   in_mem,
    input  logic [WIDTH-1:0]   in_link,
    input  logic [WIDTH-1:0]   in_imm,
    input  logic [RA_W-1:0]    in_rd,
    input  logic               in_we,
    input  logic               in_halt,
    output logic               rf_we,
    output logic [RA_W-1:0]    rf_addr,
    output logic [WIDTH-1:0]   rf_data,
    input  logic               rf_ready,
    output logic               fwd_valid,
    output logic [RA_W-1:0]    fwd_rd,
    output logic [WIDTH-1:0]   fwd_data,
    output logic [WIDTH-1:0]   final_result,
    output logic [COUNT_W-1:0] commit_count,
    output logic               halted
);

    // Queue storage, indexed by a 1-bit slot number.
    logic [WIDTH-1:0]   r_data [2];
    logic [RA_W-1:0]    r_rd   [2];
    logic [1:0]         r_we;
    logic [1:0]         r_halt;
    logic               r_head;
    logic [1:0]         r_occ;
    logic [WIDTH-1:0]   r_final;
    logic [COUNT_W-1:0] r_commit;
    logic               r_halted;

    logic [WIDTH-1:0]   w_sel_data;
    logic               w_we_in;
    logic               w_empty;
    logic               w_enq;
    logic               w_retire;
    logic               w_wr_idx;
    logic               w_tail_idx;
    logic               w_head_we;
    logic               w_tail_we;

    assign w_empty    = (r_occ == 2'd0);
    assign in_ready   = !rst && !r_halted && (r_occ != 2'd2);
    assign w_enq      = in_valid && in_ready;
    // Write slot is one past the head when an entry is already present; with a
    // same-edge pop at occupancy 1 that slot becomes the new head.
    assign w_wr_idx   = r_head ^ (r_occ == 2'd1);
    assign w_tail_idx = r_head ^ (r_occ == 2'd2);
    assign w_head_we  = r_we[r_head];
    assign w_tail_we  = r_we[w_tail_idx];
    // Non-writing entries drain without waiting for the register file.
    assign w_retire   = !w_empty && (!w_head_we || rf_ready);
    assign w_we_in    = in_we && !(R0_ZERO && (in_rd == '0));

    // Source select for the incoming result.
    always_comb begin
        w_sel_data = in_alu;
        unique case (in_sel)
            2'b00:   w_sel_data = in_alu;
            2'b01:   w_sel_data = in_mem;
            2'b10:   w_sel_data = in_link;
            default: w_sel_data = in_imm;
        endcase
    end

    // Head drives the register-file port, tail drives the forwarding tap.
    always_comb begin
        rf_we     = 1'b0;
        rf_addr   = '0;
        rf_data   = '0;
        fwd_valid = 1'b0;
        fwd_rd    = '0;
        fwd_data  = '0;
        if (!w_empty) begin
            rf_we   = w_head_we;
            rf_addr = r_rd[r_head];
            rf_data = r_data[r_head];
        end
        if (!w_empty && w_tail_we) begin
            fwd_valid = 1'b1;
            fwd_rd    = r_rd[w_tail_idx];
            fwd_data  = r_data[w_tail_idx];
        end
    end

    // Queue, retire bookkeeping and halt latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data[0] <= '0;
            r_data[1] <= '0;
            r_rd[0]   <= '0;
            r_rd[1]   <= '0;
            r_we      <= '0;
            r_halt    <= '0;
            r_head    <= 1'b0;
            r_occ     <= 2'd0;
            r_final   <= '0;
            r_commit  <= '0;
            r_halted  <= 1'b0;
        end else begin
            if (w_enq) begin
                r_data[w_wr_idx] <= w_sel_data;
                r_rd[w_wr_idx]   <= in_rd;
                r_we[w_wr_idx]   <= w_we_in;
                r_halt[w_wr_idx] <= in_halt;
            end
            if (w_retire) begin
                r_head   <= ~r_head;
                r_final  <= r_data[r_head];
                r_commit <= r_commit + COUNT_W'(1);
                if (r_halt[r_head]) begin
                    r_halted <= 1'b1;
                end
            end
            unique case ({w_enq, w_retire})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign final_result = r_final;
    assign commit_count = r_commit;
    assign halted       = r_halted;

endmodule
